// File: rtl/alut_age_responder.sv
// ALUT age responder: answers age checks and sweeps all entries, invalidating stale ones; `ALUT_AGE_INVAL_COUNT_EN adds inval_count.
// Latency: response one cycle after check_age, sweep 4 cycles/entry (+1 per write); no backpressure, requests always accepted.
module alut_age_responder #(
  parameter int MEM_DEPTH = 256,
  parameter int ENTRY_W   = 83
) (
  input  logic               pclk,
  input  logic               p_reset,
  input  logic [1:0]         command,
  input  logic [31:0]        curr_time,
  input  logic [31:0]        max_age,
  input  logic               check_age,
  input  logic [31:0]        last_accessed,
  output logic               age_confirmed,
  output logic               age_ok,
  input  logic [ENTRY_W-1:0] mem_read_data_age,
  output logic [7:0]         mem_addr_age,
  output logic               mem_write_age,
  output logic [ENTRY_W-1:0] mem_write_data_age,
  output logic               age_check_active,
  output logic [47:0]        lst_inv_addr_cmd,
  output logic [1:0]         lst_inv_port_cmd,
  output logic [8:0]         inval_count
);

  localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EVAL, S_WR, S_NEXT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         addr_q, addr_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic [47:0]        lst_addr_q;
  logic [1:0]         lst_port_q;
  logic               conf_q, ok_q;
  logic               start;
  logic               entry_stale;

  // Age wraps modulo 2^32, so an entry stamped just before a time rollover still ages correctly.
  function automatic logic in_date(input logic [31:0] now, input logic [31:0] stamp,
                                   input logic [31:0] limit);
    logic [31:0] age;
    age = now - stamp;
    return age < limit;
  endfunction

  assign start       = (command == 2'b10);
  assign entry_stale = mem_read_data_age[ENTRY_W-1] &&
                       !in_date(curr_time, mem_read_data_age[81:50], max_age);

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          addr_d  = '0;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: state_d = S_EVAL;
      S_EVAL: begin
        data_d  = mem_read_data_age;
        state_d = entry_stale ? S_WR : S_NEXT;
      end
      S_WR:   state_d = S_NEXT;
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops the write strobe without waiting for a clock.
  always_comb begin
    age_check_active   = (state_q != S_IDLE);
    mem_write_age      = (state_q == S_WR);
    mem_addr_age       = age_check_active ? addr_q : 8'd0;
    mem_write_data_age = mem_write_age ? {1'b0, data_q[ENTRY_W-2:0]} : '0;
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      lst_addr_q <= '0;
      lst_port_q <= '0;
    end else if (state_q == S_WR) begin
      lst_addr_q <= data_q[47:0];
      lst_port_q <= data_q[49:48];
    end
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      conf_q <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      conf_q <= check_age;
      ok_q   <= check_age && in_date(curr_time, last_accessed, max_age);
    end
  end

  assign age_confirmed    = conf_q;
  assign age_ok           = ok_q;
  assign lst_inv_addr_cmd = lst_addr_q;
  assign lst_inv_port_cmd = lst_port_q;

`ifdef ALUT_AGE_INVAL_COUNT_EN
  logic [8:0] inval_q, inval_d;

  always_comb begin
    inval_d = inval_q;
    if (state_q == S_IDLE && start) begin
      inval_d = '0;
    end else if (state_q == S_WR && inval_q != 9'd256) begin
      inval_d = inval_q + 9'd1;
    end
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      inval_q <= '0;
    end else begin
      inval_q <= inval_d;
    end
  end

  assign inval_count = inval_q;
`else
  assign inval_count = '0;
`endif

endmodule

// File: tb/tb_alut_age_responder.sv
// Bench for alut_age_responder: directed and random requests, full sweeps against an entry-level model, reset abort.
module tb_alut_age_responder;

  logic        pclk;
  logic        p_reset;
  logic [1:0]  command;
  logic [31:0] curr_time;
  logic [31:0] max_age;
  logic        check_age;
  logic [31:0] last_accessed;
  logic        age_confirmed;
  logic        age_ok;
  logic [82:0] mem_read_data_age;
  logic [7:0]  mem_addr_age;
  logic        mem_write_age;
  logic [82:0] mem_write_data_age;
  logic        age_check_active;
  logic [47:0] lst_inv_addr_cmd;
  logic [1:0]  lst_inv_port_cmd;
  logic [8:0]  inval_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [82:0] mem      [256];
  logic [82:0] load_mem [256];
  logic [82:0] exp_mem  [256];
  logic        load_req;
  int          exp_wr[$];
  int          exp_active;
  logic [47:0] model_lst_addr;
  logic [1:0]  model_lst_port;
  logic [8:0]  exp_inval;

  alut_age_responder dut (
    .pclk               (pclk),
    .p_reset            (p_reset),
    .command            (command),
    .curr_time          (curr_time),
    .max_age            (max_age),
    .check_age          (check_age),
    .last_accessed      (last_accessed),
    .age_confirmed      (age_confirmed),
    .age_ok             (age_ok),
    .mem_read_data_age  (mem_read_data_age),
    .mem_addr_age       (mem_addr_age),
    .mem_write_age      (mem_write_age),
    .mem_write_data_age (mem_write_data_age),
    .age_check_active   (age_check_active),
    .lst_inv_addr_cmd   (lst_inv_addr_cmd),
    .lst_inv_port_cmd   (lst_inv_port_cmd),
    .inval_count        (inval_count)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ALUT memory with one-cycle registered read
  always @(posedge pclk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= load_mem[i];
    end else if (mem_write_age) begin
      mem[mem_addr_age] <= mem_write_data_age;
    end
    mem_read_data_age <= mem[mem_addr_age];
  end

  function automatic bit ref_in_date(input logic [31:0] now, input logic [31:0] stamp,
                                     input logic [31:0] limit);
    logic [31:0] age;
    age = now - stamp;
    return age < limit;
  endfunction

  task automatic load_memory();
    @(negedge pclk);
    load_req = 1'b1;
    @(negedge pclk);
    load_req = 1'b0;
  endtask

  // Expected sweep outcome from the entry table: every valid stale entry is cleared in address order.
  task automatic build_model();
    logic [31:0] age;
    exp_wr.delete();
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = load_mem[i];
      age = curr_time - load_mem[i][81:50];
      if (load_mem[i][82] && !(age < max_age)) begin
        exp_wr.push_back(i);
        exp_mem[i][82] = 1'b0;
        model_lst_addr = load_mem[i][47:0];
        model_lst_port = load_mem[i][49:48];
      end
    end
    exp_active = 1024 + exp_wr.size();
`ifdef ALUT_AGE_INVAL_COUNT_EN
    exp_inval = 9'(exp_wr.size());
`else
    exp_inval = 9'd0;
`endif
  endtask

  task automatic run_sweep(input bit inject, input bit cmd_again);
    int cyc, active_cnt, bad;
    int obs_wr[$];
    bit pending, injected, exp_req_ok;
    cyc = 0; active_cnt = 0; pending = 0; injected = 0; exp_req_ok = 0;
    @(negedge pclk);
    command = 2'b10;
    @(negedge pclk);
    command = 2'b00;
    n_checks++;
    if (age_check_active !== 1'b1 || mem_addr_age !== 8'h00) begin
      n_fail++;
      $display("FAIL sweep_start: active=%b addr=%h, required active=1 addr=00", age_check_active, mem_addr_age);
    end
    while (age_check_active === 1'b1 && cyc < 3000) begin
      active_cnt++;
      if (pending) begin
        n_checks++;
        if (age_confirmed !== 1'b1 || age_ok !== exp_req_ok) begin
          n_fail++;
          $display("FAIL req_during_wr: confirmed=%b ok=%b, required 1 %b", age_confirmed, age_ok, exp_req_ok);
        end
        check_age = 1'b0;
        pending = 0;
      end
      if (mem_write_age === 1'b1) begin
        obs_wr.push_back(int'(mem_addr_age));
        n_checks++;
        if (mem_write_data_age !== {1'b0, load_mem[mem_addr_age][81:0]}) begin
          n_fail++;
          $display("FAIL wr_data @%h: got %h, required %h", mem_addr_age, mem_write_data_age,
                   {1'b0, load_mem[mem_addr_age][81:0]});
        end
        if (inject && !injected) begin
          check_age     = 1'b1;
          last_accessed = curr_time - $urandom_range(0, 200);
          exp_req_ok    = ref_in_date(curr_time, last_accessed, max_age);
          pending = 1; injected = 1;
        end
      end
      if (cmd_again && cyc == 100) command = 2'b10;
      if (cmd_again && cyc == 101) command = 2'b00;
      @(negedge pclk);
      cyc++;
    end
    check_age = 1'b0;
    command   = 2'b00;
    n_checks++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL sweep_timeout: still active after %0d cycles, required idle within 3000", cyc);
    end
    n_checks++;
    if (active_cnt != exp_active) begin
      n_fail++;
      $display("FAIL active_len: got %0d cycles, required %0d", active_cnt, exp_active);
    end
    n_checks++;
    bad = 0;
    if (obs_wr.size() != exp_wr.size()) bad = 1;
    else foreach (obs_wr[i]) if (obs_wr[i] != exp_wr[i]) bad++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL write_seq: got %0d writes (%0d wrong), required %0d writes", obs_wr.size(), bad, exp_wr.size());
    end
    n_checks++;
    if (lst_inv_addr_cmd !== model_lst_addr || lst_inv_port_cmd !== model_lst_port) begin
      n_fail++;
      $display("FAIL lst_inv: got %h/%0d, required %h/%0d", lst_inv_addr_cmd, lst_inv_port_cmd,
               model_lst_addr, model_lst_port);
    end
    n_checks++;
    if (inval_count !== exp_inval) begin
      n_fail++;
      $display("FAIL inval_count: got %0d, required %0d", inval_count, exp_inval);
    end
    n_checks++;
    if (mem_addr_age !== 8'h00 || mem_write_data_age !== 83'h0 || mem_write_age !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_outputs: addr=%h we=%b wdata=%h, required all 0", mem_addr_age, mem_write_age, mem_write_data_age);
    end
    n_checks++;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mem_final: %0d entries differ, required 0", bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pclk);
    n_checks++;
    if ({age_confirmed, age_ok, age_check_active, mem_write_age} !== 4'b0 || mem_addr_age !== 8'h0 ||
        mem_write_data_age !== 83'h0 || lst_inv_addr_cmd !== 48'h0 || lst_inv_port_cmd !== 2'd0 ||
        inval_count !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: conf=%b ok=%b act=%b we=%b addr=%h lst=%h/%0d inv=%0d, required all 0",
               age_confirmed, age_ok, age_check_active, mem_write_age, mem_addr_age,
               lst_inv_addr_cmd, lst_inv_port_cmd, inval_count);
    end
    p_reset = 1'b0;
    repeat (2) @(negedge pclk);
    n_checks++;
    if (age_check_active !== 1'b0 || age_confirmed !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: act=%b conf=%b, required 0 0", age_check_active, age_confirmed);
    end
    model_lst_addr = '0;
    model_lst_port = '0;
  endtask

  task automatic test_request_directed();
    logic [31:0] now_t  [4] = '{32'd1000, 32'd1000, 32'h0000_0010, 32'd1000};
    logic [31:0] last_t [4] = '{32'd950,  32'd800,  32'hFFFF_FFF0, 32'd950};
    logic [31:0] max_t  [4] = '{32'd100,  32'd100,  32'h40,        32'd0};
    bit          ok_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      curr_time = now_t[k]; max_age = max_t[k]; last_accessed = last_t[k];
      check_age = 1'b1;
      @(negedge pclk);
      check_age = 1'b0;
      n_checks++;
      if (age_confirmed !== 1'b1 || age_ok !== ok_t[k]) begin
        n_fail++;
        $display("FAIL req_case%0d: confirmed=%b ok=%b, required 1 %b", k, age_confirmed, age_ok, ok_t[k]);
      end
      @(negedge pclk);
      n_checks++;
      if (age_confirmed !== 1'b0 || age_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL req_case%0d_drop: confirmed=%b ok=%b, required 0 0", k, age_confirmed, age_ok);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_c, exp_o;
    exp_c = 0; exp_o = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge pclk);
      n_checks++;
      if (age_confirmed !== exp_c || age_ok !== exp_o) begin
        n_fail++;
        $display("FAIL b2b_req%0d: confirmed=%b ok=%b, required %b %b", i, age_confirmed, age_ok, exp_c, exp_o);
      end
      check_age = ($urandom_range(0, 2) != 0);
      curr_time = $urandom;
      max_age   = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom_range(1, 300);
      if ($urandom_range(0, 7) == 0) last_accessed = curr_time + $urandom_range(1, 50);
      else                           last_accessed = curr_time - $urandom_range(0, 400);
      exp_c = check_age;
      exp_o = check_age && ref_in_date(curr_time, last_accessed, max_age);
    end
    @(negedge pclk);
    check_age = 1'b0;
    n_checks++;
    if (age_confirmed !== exp_c || age_ok !== exp_o) begin
      n_fail++;
      $display("FAIL b2b_last: confirmed=%b ok=%b, required %b %b", age_confirmed, age_ok, exp_c, exp_o);
    end
  endtask

  task automatic test_sweep_directed();
    for (int i = 0; i < 256; i++) load_mem[i] = '0;
    load_mem[8'h05] = {1'b1, 32'd0,   2'd2, 48'h0A0B_0C0D_0E0F};
    load_mem[8'h06] = {1'b1, 32'd990, 2'd1, 48'h1122_3344_5566};
    curr_time = 32'd1000;
    max_age   = 32'd100;
    load_memory();
    build_model();
    run_sweep(1'b1, 1'b1);
    n_checks++;
    if (lst_inv_addr_cmd !== 48'h0A0B_0C0D_0E0F || lst_inv_port_cmd !== 2'd2) begin
      n_fail++;
      $display("FAIL directed_lst: got %h/%0d, required 0a0b0c0d0e0f/2", lst_inv_addr_cmd, lst_inv_port_cmd);
    end
  endtask

  task automatic test_sweep_random(input bit all_stale);
    logic [63:0] r;
    curr_time = $urandom;
    max_age   = all_stale ? 32'd0 : $urandom_range(50, 150);
    for (int i = 0; i < 256; i++) begin
      r = {$urandom, $urandom};
      load_mem[i] = {($urandom_range(0, 1) == 1), curr_time - $urandom_range(0, 300),
                     2'($urandom_range(0, 3)), r[47:0]};
    end
    load_memory();
    build_model();
    run_sweep(1'b1, all_stale);
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    for (int i = 0; i < 256; i++) load_mem[i] = '0;
    load_mem[8'h40] = {1'b1, 32'd0, 2'd3, 48'hDEAD_BEEF_0040};
    curr_time = 32'd1000;
    max_age   = 32'd100;
    load_memory();
    @(negedge pclk);
    command = 2'b10;
    @(negedge pclk);
    command = 2'b00;
    cyc = 0;
    while (!(mem_write_age === 1'b1 && mem_addr_age === 8'h40) && cyc < 2000) begin
      @(negedge pclk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 2000) begin
      n_fail++;
      $display("FAIL reach_wr40: no write at 40 within %0d cycles", cyc);
    end
    p_reset = 1'b1;
    #1;
    n_checks++;
    if (mem_write_age !== 1'b0 || age_check_active !== 1'b0 || lst_inv_addr_cmd !== 48'h0) begin
      n_fail++;
      $display("FAIL async_abort: we=%b act=%b lst=%h, required 0 0 0", mem_write_age, age_check_active, lst_inv_addr_cmd);
    end
    @(negedge pclk);
    p_reset = 1'b0;
    model_lst_addr = '0;
    model_lst_port = '0;
    n_checks++;
    if (mem[8'h40][82] !== 1'b1) begin
      n_fail++;
      $display("FAIL aborted_write: entry 40 valid=%b, required 1", mem[8'h40][82]);
    end
    load_memory();
    build_model();
    run_sweep(1'b0, 1'b0);
  endtask

  initial begin
    p_reset = 1'b1; command = 2'b00; curr_time = '0; max_age = '0;
    check_age = 1'b0; last_accessed = '0; load_req = 1'b0;
    model_lst_addr = '0; model_lst_port = '0;
    test_reset();
    test_request_directed();
    test_back_to_back();
    test_sweep_directed();
    test_sweep_random(1'b0);
    test_sweep_random(1'b1);
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alut_age_responder.md
Name: alut_age_responder

Overview:
- Responder end of the ALUT age-check handshake.
- Answers each `check_age`/`last_accessed` request from the address checker with an `age_confirmed`/`age_ok` pulse.
- Also runs a software-commanded background sweep over all 256 ALUT entries, invalidating stale valid entries in place.
- Sits beside the address checker in the ALUT, sharing the 83-bit entry format {valid, time[31:0], port[1:0], addr[47:0]}.

Parameters:
- `MEM_DEPTH`, 256, number of ALUT entries swept; the address counter is 8 bits.
- `ENTRY_W`, 83, ALUT entry width: valid bit 82, time bits 81:50, port bits 49:48, address bits 47:0.

Ports:
- `pclk`  in  1  APB clock
- `p_reset`  in  1  reset, asynchronous, active-high
- `command`  in  2  command bus; 2'b10 = start sweep, all other values ignored
- `curr_time`  in  32  free-running current time
- `max_age`  in  32  programmed maximum entry age
- `check_age`  in  1  age-check request pulse from the address checker
- `last_accessed`  in  32  entry time field; valid while `check_age`=1
- `age_confirmed`  out  1  response-valid pulse
- `age_ok`  out  1  entry in date; meaningful only while `age_confirmed`=1
- `mem_read_data_age`  in  83  ALUT read data; 1-cycle read latency
- `mem_addr_age`  out  8  ALUT address for sweep R/W
- `mem_write_age`  out  1  ALUT write strobe (high = write)
- `mem_write_data_age`  out  83  ALUT write data
- `age_check_active`  out  1  sweep in progress (status bit 1)
- `lst_inv_addr_cmd`  out  48  address of the last entry invalidated by a sweep
- `lst_inv_port_cmd`  out  2  port of the last entry invalidated by a sweep
- `inval_count`  out  9  see Optional Feature

Behaviour:
- Reset (async, `p_reset`=1): all outputs 0; sweep FSM to IDLE; sweep address counter 0.
  - Reset asserted mid-sweep aborts the sweep immediately; `mem_write_age` drops to 0 asynchronously.
- Age arithmetic: age = (`curr_time` - time) mod 2^32, i.e. unsigned 32-bit subtraction with wrap.
  - In date = age < `max_age`, unsigned.
  - `max_age`=0 makes every entry stale.
- Request path, independent of the sweep and with no memory access:
  - `check_age` sampled 1 at edge N ⇒ `age_confirmed`=1 and `age_ok`=(in-date result for `last_accessed`) on cycle N+1, each for exactly one cycle.
  - `age_ok` is 0 whenever `age_confirmed`=0.
  - Back-to-back requests each get their own response.
  - A request is serviced normally while a sweep is running.
- Sweep FSM states: IDLE, RD, WAIT, EVAL, WR, NEXT.
  - IDLE: `command`==2'b10 ⇒ RD, address counter = 0.
  - RD: `mem_addr_age` = counter, `mem_write_age`=0 ⇒ WAIT.
  - WAIT: memory latency cycle ⇒ EVAL.
  - EVAL: if read data valid bit = 1 and the entry is stale ⇒ WR; otherwise ⇒ NEXT.
  - WR: one cycle with `mem_write_age`=1, same address, `mem_write_data_age` = read data with bit 82 cleared and all other bits unchanged.
    - On this edge, `lst_inv_addr_cmd` ⇐ data[47:0] and `lst_inv_port_cmd` ⇐ data[49:48].
    - ⇒ NEXT.
  - NEXT: if counter==255 ⇒ IDLE; otherwise counter+1 ⇒ RD.
  - `command`==2'b10 while not in IDLE is ignored; no restart.
- `age_check_active` = 1 in every state except IDLE.
- `mem_write_age` = 1 only in WR. Outside a sweep, `mem_addr_age`=0 and `mem_write_data_age`=0.
- Invalid entries (bit 82=0) are never written and never update the last-invalidated registers.
- `lst_inv_*` hold their values across sweeps until reset.
- Sweep length: 4 cycles per entry with no invalidation, 5 with invalidation.
  - Idle-to-idle is 1024–1280 cycles.
  - `age_check_active` falls on the edge after NEXT at address 255.

Optional Feature:
- Macro `ALUT_AGE_INVAL_COUNT_EN`.
- Defined:
  - `inval_count` clears to 0 on sweep start (IDLE⇒RD).
  - It increments on every WR cycle and saturates at 256.
  - It holds after the sweep ends.
- Undefined:
  - `inval_count` tied to 0; no counter logic.
  - All other behaviour is identical.

Test Plan:
- Request in date: `curr_time`=1000, `max_age`=100, `last_accessed`=950 with a 1-cycle `check_age` ⇒ next cycle `age_confirmed`=1, `age_ok`=1; both 0 the cycle after.
- Stale and wrap cases:
  - `last_accessed`=800 ⇒ `age_ok`=0.
  - `curr_time`=0x0000_0010, `last_accessed`=0xFFFF_FFF0, `max_age`=0x40 ⇒ age 0x20 ⇒ `age_ok`=1.
  - `max_age`=0 ⇒ `age_ok`=0.
- Full sweep: preload entry 0x05 as valid, time 0, port 2, address 0x0A0B0C0D0E0F, and entry 0x06 as valid, time 990; all others invalid. `curr_time`=1000, `max_age`=100, `command`=2'b10 for one cycle ⇒
  - one write only, to address 0x05, with bit 82 cleared and bits 81:0 unchanged;
  - `lst_inv_addr_cmd`=0x0A0B0C0D0E0F, `lst_inv_port_cmd`=2;
  - `age_check_active` high for 1025 cycles;
  - `inval_count`=1 with the macro defined, 0 without.
- Concurrent request: issue `check_age` while the sweep is in WR ⇒ the response arrives on the next cycle, unchanged; the sweep write sequence is unaffected.
- Command while busy: `command`=2'b10 again mid-sweep ⇒ no restart; total sweep length unchanged.
- Reset mid-sweep: assert `p_reset` during WR at address 0x40 ⇒ `mem_write_age`=0 and `age_check_active`=0 immediately; after release the FSM is IDLE and a new sweep starts at address 0.
